// File: rtl/data_port_arbiter_if.sv
// Bundle of the two processor data ports, the shared downstream data
// port and the arbiter status outputs.
interface data_port_arbiter_if #(
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic          data_req_1;
    logic          data_write_enable_1;
    logic [3:0]    data_be_1;
    logic [31:0]   data_addr_1;
    logic [31:0]   data_write_1;
    logic          data_gnt_1;
    logic          data_r_valid_1;
    logic [31:0]   data_read_1;

    logic          data_req_2;
    logic          data_write_enable_2;
    logic [3:0]    data_be_2;
    logic [31:0]   data_addr_2;
    logic [31:0]   data_write_2;
    logic          data_gnt_2;
    logic          data_r_valid_2;
    logic [31:0]   data_read_2;

    logic          data_req;
    logic          data_write_enable;
    logic [3:0]    data_be;
    logic [31:0]   data_addr;
    logic [31:0]   data_write;
    logic          data_gnt;
    logic          data_r_valid;
    logic [31:0]   data_read;

    logic [CW-1:0] outstanding;
    logic          err_spurious;

    modport slave (
        input  data_req_1, data_write_enable_1, data_be_1,
        input  data_addr_1, data_write_1,
        output data_gnt_1, data_r_valid_1, data_read_1,
        input  data_req_2, data_write_enable_2, data_be_2,
        input  data_addr_2, data_write_2,
        output data_gnt_2, data_r_valid_2, data_read_2,
        output data_req, data_write_enable, data_be,
        output data_addr, data_write,
        input  data_gnt, data_r_valid, data_read,
        output outstanding, err_spurious
    );

    modport master (
        output data_req_1, data_write_enable_1, data_be_1,
        output data_addr_1, data_write_1,
        input  data_gnt_1, data_r_valid_1, data_read_1,
        output data_req_2, data_write_enable_2, data_be_2,
        output data_addr_2, data_write_2,
        input  data_gnt_2, data_r_valid_2, data_read_2,
        input  data_req, data_write_enable, data_be,
        input  data_addr, data_write,
        output data_gnt, data_r_valid, data_read,
        input  outstanding, err_spurious
    );
endinterface

// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one data memory port between two
// processors, with an in-order owner FIFO for response routing.
module data_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                res,
    data_port_arbiter_if.slave  bus
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    // id 0 is processor 1, id 1 is processor 2
    logic          prio;
    logic          hold_valid;
    logic          hold_id;
    logic          owner_q [MAX_OUTSTANDING];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          err_q;

    logic sel;
    logic full;
    logic req_out;
    logic accept;
    logic pop;
    logic head;

    always_comb begin
        sel = prio;
        if (hold_valid)
            sel = hold_id;
        else if (bus.data_req_1 != bus.data_req_2)
            sel = bus.data_req_2;
    end

    assign full    = (count == FULL_CNT);
    assign req_out = (bus.data_req_1 | bus.data_req_2 | hold_valid) & ~full;
    assign accept  = req_out & bus.data_gnt;
    assign pop     = bus.data_r_valid & (count != '0);
    assign head    = owner_q[rd_ptr];

    assign bus.data_req   = req_out;
    assign bus.data_gnt_1 = accept & ~sel;
    assign bus.data_gnt_2 = accept & sel;

    always_comb begin
        bus.data_write_enable = 1'b0;
        bus.data_be           = '0;
        bus.data_addr         = '0;
        bus.data_write        = '0;
        if (req_out) begin
            if (sel) begin
                bus.data_write_enable = bus.data_write_enable_2;
                bus.data_be           = bus.data_be_2;
                bus.data_addr         = bus.data_addr_2;
                bus.data_write        = bus.data_write_2;
            end else begin
                bus.data_write_enable = bus.data_write_enable_1;
                bus.data_be           = bus.data_be_1;
                bus.data_addr         = bus.data_addr_1;
                bus.data_write        = bus.data_write_1;
            end
        end
    end

    assign bus.data_r_valid_1 = pop & ~head;
    assign bus.data_r_valid_2 = pop & head;
    assign bus.data_read_1    = (pop & ~head) ? bus.data_read : '0;
    assign bus.data_read_2    = (pop & head) ? bus.data_read : '0;
    assign bus.outstanding    = count;
    assign bus.err_spurious   = err_q;

    always_ff @(posedge clk) begin
        if (accept)
            owner_q[wr_ptr] <= sel;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            prio       <= 1'b0;
            hold_valid <= 1'b0;
            hold_id    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prio       <= ~sel;
                hold_valid <= 1'b0;
            end else if (req_out) begin
                // stalled downstream: lock selection until granted
                hold_valid <= 1'b1;
                hold_id    <= sel;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
            if (bus.data_r_valid && count == '0)
                err_q <= 1'b1;
        end
    end
endmodule

// File: doc/data_port_arbiter.md
# data_port_arbiter

Round-robin arbiter that shares the single data memory port of the memory/peripheral subsystem between processor 1 and processor 2. It selects one requester per cycle, holds the selection stable until the downstream grant, and records the owner of every accepted transaction in an in-order tracking FIFO. Responses are routed back to the correct processor from that FIFO. It sits between the two processors' data interfaces and the subsystem's DATA_* port.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: depth of the owner-tracking FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  synchronous, active-high reset.
- data_req_1 / data_req_2  in  1  request from processor 1 / 2.
- data_write_enable_1 / _2  in  1  write enable.
- data_be_1 / _2  in  4  byte enables.
- data_addr_1 / _2  in  32  address.
- data_write_1 / _2  in  32  write data.
- data_gnt_1 / _2  out  1  grant to processor 1 / 2.
- data_r_valid_1 / _2  out  1  response valid to processor 1 / 2.
- data_read_1 / _2  out  32  read data to processor 1 / 2.
- data_req  out  1  downstream request.
- data_write_enable, data_be, data_addr, data_write  out  1/4/32/32  downstream request fields, muxed from the selected processor.
- data_gnt  in  1  downstream grant.
- data_r_valid  in  1  downstream response valid; one per accepted transaction, reads and writes alike, in order.
- data_read  in  32  downstream read data.
- outstanding  out  log2(MAX_OUTSTANDING)+1  number of transactions accepted but not yet answered.
- err_spurious  out  1  sticky flag: data_r_valid arrived with the FIFO empty.

## Operation
- Registers: prio (0 = processor 1 wins a conflict, 1 = processor 2 wins), hold_valid, hold_id, FIFO storage/rd_ptr/wr_ptr/count, err_spurious.
- Selection, combinational:
  - If hold_valid, sel = hold_id.
  - Otherwise, if only one data_req_k is high, sel = k.
  - Otherwise, if both are high, sel = prio winner.
- full = (count == MAX_OUTSTANDING).
- data_req = (data_req_1 | data_req_2 | hold_valid) & !full. Downstream fields are driven from sel; with no request they output 0.
- data_gnt_k = data_gnt & data_req & (sel == k). Any other gnt output is 0.
- Accept (data_req & data_gnt):
  - Push sel into the FIFO.
  - prio ← other processor than sel.
  - hold_valid ← 0.
- Stall (data_req & !data_gnt):
  - hold_valid ← 1 and hold_id ← sel, so the pending transaction stays locked to the same processor.
- A processor keeps its request asserted until it is granted (same rule as downstream). The arbiter never switches selection while a downstream request is pending.
- Response:
  - On data_r_valid with count > 0, owner = FIFO head. Pop the FIFO.
  - data_r_valid_owner = 1 and data_read_owner = data_read. The other processor sees r_valid 0 and data_read 0.
- Spurious response: data_r_valid with count == 0 sets err_spurious, is not forwarded and does not change the FIFO. err_spurious is cleared only by res.
- Full:
  - data_req = 0 and no grants are issued, even if a pop happens in the same cycle.
  - hold_valid keeps its value. The held transaction is re-presented once count < MAX_OUTSTANDING.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- outstanding = count.

## Timing
- Zero-latency paths, all combinational:
  - processor req to downstream req;
  - downstream gnt to processor gnt;
  - downstream r_valid/read to processor r_valid/read.
- Register updates take effect at the next rising edge of clk.
- Back-to-back grants are allowed: one transaction can be accepted per cycle, alternating processors while both request.
- Response routing latency: 0 cycles from data_r_valid.
- Reset (res high at a rising edge), including mid-transaction:
  - prio = 0, hold_valid = 0, hold_id = 0;
  - FIFO empty (count = 0, pointers 0), err_spurious = 0.
  - Responses to transactions accepted before reset are then treated as spurious.
- Outputs while res is high depend only on register state after the first reset edge:
  - data_gnt_1/2 follow the rules above;
  - data_r_valid_1/2 = 0 unless the FIFO is non-empty;
  - outstanding = 0.

## Test plan
- Single requester: processor 1 reads 0x0000_1000, downstream gnt immediate, r_valid two cycles later with 0xDEAD_BEEF -> data_gnt_1 in the same cycle; data_r_valid_1 = 1 with data_read_1 = 0xDEAD_BEEF; processor 2 outputs stay 0; outstanding goes 0→1→0.
- Conflict after reset: both request continuously, data_gnt always 1 -> grants alternate 1,2,1,2; the response sequence is routed 1,2,1,2 in order.
- Stall lock: processor 2 requests, data_gnt held low 3 cycles, processor 1 requests from cycle 1 -> downstream address stays at processor 2's for all 3 cycles; the first grant goes to processor 2 and the next to processor 1.
- Full: MAX_OUTSTANDING = 4, four writes granted with no response -> data_req = 0 and outstanding = 4. One r_valid -> the held request is granted in the next cycle, not the same one.
- Spurious: data_r_valid with outstanding = 0 -> err_spurious = 1 and stays 1; no processor r_valid; res clears it.
- Reset mid-flight: two transactions outstanding, res pulsed -> outstanding = 0 and prio = 0; later r_valid pulses set err_spurious and are not forwarded.
